// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter with bounded bus lock and registered read data.
module periph_bus_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  logic             rr_q, rr_d;
  logic             lock_q, lock_d;
  logic             lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic             owner_req_c, other_req_c, lock_act_c;
  logic             gnt_any_c, gnt_idx_c, forced_c;
  logic             g_lock_c, g_we_c, g_other_req_c;
  logic [CNT_W-1:0] base_cnt_c;

  // Arbitration: lock owner first (with starvation escape), else round-robin.
  always_comb begin
    gnt_any_c   = 1'b0;
    gnt_idx_c   = 1'b0;
    forced_c    = 1'b0;
    owner_req_c = lock_owner_q ? m1_req_i : m0_req_i;
    other_req_c = lock_owner_q ? m0_req_i : m1_req_i;
    lock_act_c  = lock_q && owner_req_c;
    if (lock_act_c) begin
      gnt_any_c = 1'b1;
      if (lock_cnt_q == CNT_MAX && other_req_c) begin
        gnt_idx_c = ~lock_owner_q;
        forced_c  = 1'b1;
      end else begin
        gnt_idx_c = lock_owner_q;
      end
    end else if (m0_req_i && m1_req_i) begin
      gnt_any_c = 1'b1;
      gnt_idx_c = rr_q;
    end else if (m0_req_i) begin
      gnt_any_c = 1'b1;
      gnt_idx_c = 1'b0;
    end else if (m1_req_i) begin
      gnt_any_c = 1'b1;
      gnt_idx_c = 1'b1;
    end
  end

  // Grant outputs and bus mux; bus idles at zero without a grant.
  always_comb begin
    m0_gnt_o = gnt_any_c && !gnt_idx_c;
    m1_gnt_o = gnt_any_c && gnt_idx_c;
    addr_o   = '0;
    we_o     = 1'b0;
    wdata_o  = '0;
    if (gnt_any_c) begin
      addr_o  = gnt_idx_c ? m1_addr_i  : m0_addr_i;
      we_o    = gnt_idx_c ? m1_we_i    : m0_we_i;
      wdata_o = gnt_idx_c ? m1_wdata_i : m0_wdata_i;
    end
  end

  // Next-state: round-robin pointer, lock tracking, read capture.
  always_comb begin
    rr_d          = rr_q;
    lock_d        = lock_q;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata_d       = rdata_q;
    g_lock_c      = gnt_idx_c ? m1_lock_i : m0_lock_i;
    g_we_c        = gnt_idx_c ? m1_we_i   : m0_we_i;
    g_other_req_c = gnt_idx_c ? m0_req_i  : m1_req_i;
    // A lock taken fresh (or by a new owner) starts counting from zero.
    base_cnt_c    = (lock_act_c && !forced_c) ? lock_cnt_q : '0;
    if (gnt_any_c) begin
      rr_d = ~gnt_idx_c;
      if (!g_we_c) begin
        rdata_d   = rdata_i;
        rvalid0_d = !gnt_idx_c;
        rvalid1_d = gnt_idx_c;
      end
      if (forced_c || !g_lock_c) begin
        lock_d     = 1'b0;
        lock_cnt_d = '0;
      end else begin
        lock_d       = 1'b1;
        lock_owner_d = gnt_idx_c;
        lock_cnt_d   = (g_other_req_c && base_cnt_c != CNT_MAX) ?
                       base_cnt_c + CNT_W'(1) : base_cnt_c;
      end
    end else begin
      lock_d     = 1'b0;
      lock_cnt_d = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q         <= 1'b0;
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata_q      <= rdata_d;
    end
  end

  assign m0_rvalid_o = rvalid0_q;
  assign m1_rvalid_o = rvalid1_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: directed vectors, per-cycle expectations.
module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
  logic [13:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [13:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [13:0] addr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = '0;
  logic [31:0] rdata_o;

  periph_bus_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_LOCK(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .rdata_o(rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  g;      // 0 none, 1 M0, 2 M1
    logic [13:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        rv0;
    logic        rv1;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic        pend_rv0 = 1'b0, pend_rv1 = 1'b0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // One cycle of stimulus; eg is the hand-determined grant owner.
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic l0,
                      input logic [13:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic l1,
                      input logic [13:0] a1, input logic [31:0] d1,
                      input logic [31:0] rdi, input logic [1:0] eg);
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni = rst;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    rdata_i = rdi;
    e.g     = eg;
    e.addr  = (eg == 2'd1) ? a0 : (eg == 2'd2) ? a1 : 14'h0;
    e.we    = (eg == 2'd1) ? w0 : (eg == 2'd2) ? w1 : 1'b0;
    e.wdata = (eg == 2'd1) ? d0 : (eg == 2'd2) ? d1 : 32'h0;
    e.rv0   = pend_rv0;
    e.rv1   = pend_rv1;
    e.rdata = exp_rdata;
    exp_q.push_back(e);
    if (!rst) begin
      pend_rv0  = 1'b0;
      pend_rv1  = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      pend_rv0 = (eg == 2'd1) && !w0;
      pend_rv1 = (eg == 2'd2) && !w1;
      if ((eg == 2'd1 && !w0) || (eg == 2'd2 && !w1)) exp_rdata = rdi;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'hFFFF_FFFF, 2'd0);
  endtask

  // Monitor: compare the DUT's presented bus/grant/read outputs against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant", {30'h0, m1_gnt, m0_gnt}, {30'h0, e.g == 2'd2, e.g == 2'd1});
        chk("addr_o", {18'h0, addr_o}, {18'h0, e.addr});
        chk("we_o", {31'h0, we_o}, {31'h0, e.we});
        chk("wdata_o", wdata_o, e.wdata);
        chk("rvalid", {30'h0, m1_rvalid, m0_rvalid}, {30'h0, e.rv1, e.rv0});
        chk("rdata_o", rdata_o, e.rdata);
      end
    end
  end

  initial begin
    int k;
    logic [1:0] eg;
    // Reset, idle bus
    step(1'b0, 0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd0);
    step(1'b0, 0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd0);
    // 1: M0 read of 0x800, data returns next cycle
    step(1'b1, 1, 0, 0, 14'h800, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0000_00A5, 2'd1);
    // 6: ten idle cycles, rdata_o holds
    idle(10);
    // 2: re-reset, then both write every cycle -> alternate M0,M1
    step(1'b0, 0, 0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1, 1, 0, 14'h10 + 14'(i), 32'hA000_0000 + 32'(i),
                 1, 1, 0, 14'h20 + 14'(i), 32'hB000_0000 + 32'(i),
                 32'h0, (i % 2 == 0) ? 2'd1 : 2'd2);
    // 3: M0 alone sets preference to M1, then M1 locked burst of 20 with M0 waiting
    step(1'b1, 1, 1, 0, 14'h100, 32'h1111_0000, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd1);
    k = 0;
    for (int c = 0; c < 21; c++) begin
      eg = (c == 16) ? 2'd1 : 2'd2;
      step(1'b1, 1, 1, 0, 14'h100, 32'h1111_0000 + 32'(c),
                 1, 1, 1, 14'h400 + 14'(k), 32'hC000_0000 + 32'(k), 32'h0, eg);
      if (eg == 2'd2) k++;
    end
    step(1'b1, 1, 1, 0, 14'h101, 32'h2222_0000, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd1);
    // 4: M0 locks, M1 waits, M0 drops -> M1 same cycle; then gnt+rvalid overlap
    step(1'b1, 1, 1, 1, 14'h200, 32'h3333_0000, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd1);
    step(1'b1, 1, 1, 1, 14'h201, 32'h3333_0001, 1, 1, 0, 14'h300, 32'h4444_0000, 32'h0, 2'd1);
    step(1'b1, 0, 0, 0, 14'h0, 32'h0, 1, 0, 0, 14'h301, 32'h0, 32'h0000_5A5A, 2'd2);
    step(1'b1, 1, 0, 0, 14'h202, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0000_0077, 2'd1);
    step(1'b1, 1, 0, 0, 14'h203, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'h0000_0088, 2'd1);
    idle(1);
    // 5: reset in an M0 read grant cycle -> no rvalid, rr back to M0
    step(1'b1, 1, 1, 0, 14'h210, 32'h5555_0000, 0, 0, 0, 14'h0, 32'h0, 32'h0, 2'd1);
    step(1'b0, 1, 0, 0, 14'h211, 32'h0, 0, 0, 0, 14'h0, 32'h0, 32'hDEAD_BEEF, 2'd1);
    step(1'b1, 1, 1, 0, 14'h212, 32'h6666_0000, 1, 1, 0, 14'h312, 32'h7777_0000, 32'h0, 2'd1);
    idle(2);
    @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
